// File: rtl/bp_pair_correlator_if.sv
// Snapshot handshake bundle between the pair correlator and its readout consumer.
interface bp_pair_correlator_if #(
  parameter int unsigned N_PAIR = 4,
  parameter int unsigned CNTW   = 17
);
  logic                   o_valid;
  logic                   i_ready;
  logic [N_PAIR*CNTW-1:0] o_countX;
  logic [N_PAIR*CNTW-1:0] o_countY;
  logic [N_PAIR*CNTW-1:0] o_countIsect;
  logic [N_PAIR*CNTW-1:0] o_countSymdiff;
  logic                   o_overrun;

  // Producer side: the correlator
  modport master (
    output o_valid, o_countX, o_countY, o_countIsect, o_countSymdiff, o_overrun,
    input  i_ready
  );

  // Consumer side: metric / readout logic
  modport slave (
    input  o_valid, o_countX, o_countY, o_countIsect, o_countSymdiff, o_overrun,
    output i_ready
  );
endinterface

// File: rtl/bp_pair_correlator.sv
// Pair correlator: samples probes at a programmable period, routes two probes per
// pair channel and counts X, Y, X&Y and X^Y over windows of 2^k samples.
module bp_pair_correlator #(
  parameter  int unsigned N_PROBE               = 8,
  parameter  int unsigned N_PAIR                = 4,
  parameter  int unsigned MAX_WINDOW_LENGTH_EXP = 16,
  parameter  int unsigned MAX_SAMPLE_PERIOD_EXP = 15,
  localparam int unsigned SELW                  = $clog2(N_PROBE),
  localparam int unsigned CNTW                  = MAX_WINDOW_LENGTH_EXP + 1,
  localparam int unsigned WEXPW                 = $clog2(MAX_WINDOW_LENGTH_EXP + 1)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_cg,
  input  logic                             i_enable,
  input  logic                             i_oneShot,
  input  logic [WEXPW-1:0]                 i_windowLengthExp,
  input  logic [MAX_SAMPLE_PERIOD_EXP-1:0] i_samplePeriod,
  input  logic [N_PAIR*SELW-1:0]           i_pairSelX,
  input  logic [N_PAIR*SELW-1:0]           i_pairSelY,
  input  logic [N_PROBE-1:0]               i_probe,
  output logic                             o_busy,
  bp_pair_correlator_if.master             snap
);

  localparam int unsigned PERW = MAX_SAMPLE_PERIOD_EXP;
  localparam int unsigned PADW = 1 << SELW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [N_PROBE-1:0]            sync1_q, sync2_q;
  logic [PADW-1:0]               probe_pad;
  logic [WEXPW-1:0]              k_q, k_clamp_c;
  logic [PERW-1:0]               period_q, div_q;
  logic [N_PAIR-1:0][SELW-1:0]   selx_q, sely_q;
  logic [CNTW-1:0]               cnt_q, win_len_c;
  logic [N_PAIR-1:0][CNTW-1:0]   acc_x_q, acc_y_q, acc_i_q, acc_s_q;
  logic [N_PAIR-1:0][CNTW-1:0]   snap_x_q, snap_y_q, snap_i_q, snap_s_q;
  logic [N_PAIR-1:0]             x_c, y_c;
  logic                          start_c, strobe_c, win_end_c;
  logic                          valid_q, overrun_q;

  // Out-of-range selects land on zero-padded probe bits
  assign probe_pad = PADW'(sync2_q);
  assign win_len_c = CNTW'(1) << k_q;

  // Window exponent clamp: 0 behaves as 1, above the maximum saturates
  always_comb begin
    k_clamp_c = i_windowLengthExp;
    if (i_windowLengthExp == '0) begin
      k_clamp_c = WEXPW'(1);
    end else if (i_windowLengthExp > WEXPW'(MAX_WINDOW_LENGTH_EXP)) begin
      k_clamp_c = WEXPW'(MAX_WINDOW_LENGTH_EXP);
    end
  end

  // Per-pair routing of the synchronised probes
  always_comb begin
    x_c = '0;
    y_c = '0;
    for (int p = 0; p < int'(N_PAIR); p++) begin
      x_c[p] = probe_pad[selx_q[p]];
      y_c[p] = probe_pad[sely_q[p]];
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic; frozen while the clock gate is low
  always_comb begin
    state_d = state_q;
    if (i_cg) begin
      case (state_q)
        S_IDLE: if (i_enable) state_d = S_RUN;
        S_RUN: begin
          if (win_end_c) begin
            if (i_oneShot || !i_enable) state_d = S_DONE;
          end else if (!i_enable) begin
            state_d = S_IDLE;
          end
        end
        S_DONE:  if (!valid_q || snap.i_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM output decode: run start, sample strobe and window end
  always_comb begin
    start_c   = 1'b0;
    strobe_c  = 1'b0;
    win_end_c = 1'b0;
    if (i_cg) begin
      start_c   = (state_q == S_IDLE) && i_enable;
      strobe_c  = (state_q == S_RUN) && (div_q == period_q);
      win_end_c = strobe_c && ((cnt_q + CNTW'(1)) == win_len_c);
    end
  end

  // Busy flag tracks the RUN state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_busy <= 1'b0;
    else          o_busy <= (state_d == S_RUN);
  end

  // Two-flop probe synchroniser
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else if (i_cg) begin
      sync1_q <= i_probe;
      sync2_q <= sync1_q;
    end
  end

  // Config latch at run start and at every window boundary
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      k_q      <= WEXPW'(1);
      period_q <= '0;
      selx_q   <= '0;
      sely_q   <= '0;
    end else if (start_c || win_end_c) begin
      k_q      <= k_clamp_c;
      period_q <= i_samplePeriod;
      selx_q   <= i_pairSelX;
      sely_q   <= i_pairSelY;
    end
  end

  // Sample divider and per-window sample counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      if (start_c || strobe_c)             div_q <= '0;
      else if (i_cg && state_q == S_RUN)   div_q <= div_q + PERW'(1);
      if (start_c || win_end_c)            cnt_q <= '0;
      else if (strobe_c)                   cnt_q <= cnt_q + CNTW'(1);
    end
  end

  // Accumulators restart at run start and after each window end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || start_c || win_end_c) begin
      acc_x_q <= '0;
      acc_y_q <= '0;
      acc_i_q <= '0;
      acc_s_q <= '0;
    end else if (strobe_c) begin
      for (int p = 0; p < int'(N_PAIR); p++) begin
        acc_x_q[p] <= acc_x_q[p] + CNTW'(x_c[p]);
        acc_y_q[p] <= acc_y_q[p] + CNTW'(y_c[p]);
        acc_i_q[p] <= acc_i_q[p] + CNTW'(x_c[p] & y_c[p]);
        acc_s_q[p] <= acc_s_q[p] + CNTW'(x_c[p] ^ y_c[p]);
      end
    end
  end

  // Snapshot registers include the final sample of the window
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      snap_x_q <= '0;
      snap_y_q <= '0;
      snap_i_q <= '0;
      snap_s_q <= '0;
    end else if (win_end_c) begin
      for (int p = 0; p < int'(N_PAIR); p++) begin
        snap_x_q[p] <= acc_x_q[p] + CNTW'(x_c[p]);
        snap_y_q[p] <= acc_y_q[p] + CNTW'(y_c[p]);
        snap_i_q[p] <= acc_i_q[p] + CNTW'(x_c[p] & y_c[p]);
        snap_s_q[p] <= acc_s_q[p] + CNTW'(x_c[p] ^ y_c[p]);
      end
    end
  end

  // Output handshake stays live regardless of the clock gate
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (win_end_c)                   valid_q <= 1'b1;
      else if (valid_q && snap.i_ready) valid_q <= 1'b0;
      if (start_c)                                      overrun_q <= 1'b0;
      else if (win_end_c && valid_q && !snap.i_ready)   overrun_q <= 1'b1;
    end
  end

  assign snap.o_valid        = valid_q;
  assign snap.o_overrun      = overrun_q;
  assign snap.o_countX       = snap_x_q;
  assign snap.o_countY       = snap_y_q;
  assign snap.o_countIsect   = snap_i_q;
  assign snap.o_countSymdiff = snap_s_q;

endmodule

// File: tb/tb_bp_pair_correlator.sv
// Directed bench for bp_pair_correlator with a queue-based snapshot scoreboard.
module tb_bp_pair_correlator;

  localparam int unsigned CNTW = 17;

  typedef struct {
    int n;
    int x0, y0, i0, s0;
    int x1, y1, i1, s1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, cg, en, en2, one_shot, ready, ready2;
  logic [4:0]  kexp;
  logic [14:0] period;
  logic [11:0] selx, sely;
  logic [2:0]  sel2x, sel2y;
  logic [7:0]  probe_static, probe_w;
  logic        tog_en, tog_bit;
  logic        busy, busy2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int c0    = 0;
  exp_t exp_q[$];
  exp_t exp2_q[$];
  exp_t e1, e2;

  bp_pair_correlator_if #(.N_PAIR(4), .CNTW(CNTW)) bus ();
  bp_pair_correlator_if #(.N_PAIR(1), .CNTW(CNTW)) bus2 ();

  assign probe_w     = {probe_static[7:2], probe_static[1] | tog_bit, probe_static[0]};
  assign bus.i_ready  = ready;
  assign bus2.i_ready = ready2;

  bp_pair_correlator #(
    .N_PROBE(8), .N_PAIR(4), .MAX_WINDOW_LENGTH_EXP(16), .MAX_SAMPLE_PERIOD_EXP(15)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_enable(en), .i_oneShot(one_shot),
    .i_windowLengthExp(kexp), .i_samplePeriod(period),
    .i_pairSelX(selx), .i_pairSelY(sely), .i_probe(probe_w),
    .o_busy(busy), .snap(bus)
  );

  bp_pair_correlator #(
    .N_PROBE(5), .N_PAIR(1), .MAX_WINDOW_LENGTH_EXP(16), .MAX_SAMPLE_PERIOD_EXP(15)
  ) dut_oor (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_enable(en2), .i_oneShot(one_shot),
    .i_windowLengthExp(kexp), .i_samplePeriod(period),
    .i_pairSelX(sel2x), .i_pairSelY(sel2y), .i_probe(probe_w[4:0]),
    .o_busy(busy2), .snap(bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Probe 1 alternates every cycle while toggling is enabled
  always @(posedge clk) begin
    #1;
    if (tog_en) tog_bit = ~tog_bit;
    else        tog_bit = 1'b0;
  end

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int fld(input logic [4*CNTW-1:0] v, input int p);
    return int'(v[p*CNTW +: CNTW]);
  endfunction

  task automatic push_exp(input int n, input int x0, input int y0, input int i0, input int s0,
                          input int x1, input int y1, input int i1, input int s1);
    exp_t e;
    e.n = n; e.x0 = x0; e.y0 = y0; e.i0 = i0; e.s0 = s0;
    e.x1 = x1; e.y1 = y1; e.i1 = i1; e.s1 = s1;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor for the main instance: compares on every accepted snapshot
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected snapshot", 1, 0);
      end else begin
        e1 = exp_q.pop_front();
        check("p0 countX",       fld(bus.o_countX, 0),       e1.x0);
        check("p0 countY",       fld(bus.o_countY, 0),       e1.y0);
        check("p0 countIsect",   fld(bus.o_countIsect, 0),   e1.i0);
        check("p0 countSymdiff", fld(bus.o_countSymdiff, 0), e1.s0);
        check("p1 countX",       fld(bus.o_countX, 1),       e1.x1);
        check("p1 countY",       fld(bus.o_countY, 1),       e1.y1);
        check("p1 countIsect",   fld(bus.o_countIsect, 1),   e1.i1);
        check("p1 countSymdiff", fld(bus.o_countSymdiff, 1), e1.s1);
        for (int p = 0; p < 4; p++) begin
          int cx, cy, ci, cs;
          cx = fld(bus.o_countX, p);
          cy = fld(bus.o_countY, p);
          ci = fld(bus.o_countIsect, p);
          cs = fld(bus.o_countSymdiff, p);
          check("inv isect<=min", longint'(ci <= cx && ci <= cy), 1);
          check("inv x+y=2i+s", cx + cy, 2 * ci + cs);
          check("inv bound", longint'(cx <= e1.n && cy <= e1.n && ci <= e1.n && cs <= e1.n), 1);
        end
      end
    end
  end

  // Scoreboard monitor for the out-of-range-select instance
  always @(negedge clk) begin
    if (rst_n && bus2.o_valid && bus2.i_ready) begin
      if (exp2_q.size() == 0) begin
        check("oor unexpected snapshot", 1, 0);
      end else begin
        e2 = exp2_q.pop_front();
        check("oor countX",       int'(bus2.o_countX),       e2.x0);
        check("oor countY",       int'(bus2.o_countY),       e2.y0);
        check("oor countIsect",   int'(bus2.o_countIsect),   e2.i0);
        check("oor countSymdiff", int'(bus2.o_countSymdiff), e2.s0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    tick();
    en = 1'b1;
    c0 = cyc;
  endtask

  // Waits for o_valid on the selected instance; lat is cycles since start()
  task automatic wait_valid(input string name, input bit second, input int budget, output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if ((second ? bus2.o_valid : bus.o_valid) == 1'b1) begin
        lat = cyc - c0;
        break;
      end
    end
    if (lat < 0) check({name, " timeout"}, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int lat, got, prev, bad, nv;
    rst_n = 1'b0; cg = 1'b1; en = 1'b0; en2 = 1'b0; one_shot = 1'b0;
    ready = 1'b1; ready2 = 1'b1; kexp = 5'd4; period = '0;
    selx  = {3'd1, 3'd2, 3'd0, 3'd0};
    sely  = {3'd2, 3'd3, 3'd3, 3'd1};
    sel2x = 3'd6; sel2y = 3'd0;
    probe_static = 8'b0000_1001;
    tog_en = 1'b0; tog_bit = 1'b0;

    // Reset and idle
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset valid", bus.o_valid, 0);
    check("reset overrun", bus.o_overrun, 0);
    check("reset counts", longint'(|{bus.o_countX, bus.o_countY, bus.o_countIsect, bus.o_countSymdiff}), 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || bus.o_valid || bus.o_overrun ||
          |{bus.o_countX, bus.o_countY, bus.o_countIsect, bus.o_countSymdiff}) bad++;
    end
    check("idle outputs nonzero cycles", bad, 0);

    // Basic window: k=4, period 0, one-shot, probe1 alternating
    tog_en = 1'b1; one_shot = 1'b1; kexp = 5'd4; period = 15'd0;
    repeat (4) tick();
    push_exp(16, 16, 8, 8, 8, 16, 16, 16, 0);
    start();
    @(negedge clk);
    check("basic busy before run", busy, 0);
    @(negedge clk);
    check("basic busy in run", busy, 1);
    wait_valid("basic", 1'b0, 60, lat);
    check("basic valid latency", lat, 17);
    check("basic busy after window", busy, 0);
    tick();
    en = 1'b0; tog_en = 1'b0;
    repeat (4) tick();

    // Back-to-back windows: k=2, period 3, continuous
    one_shot = 1'b0; kexp = 5'd2; period = 15'd3;
    for (int i = 0; i < 5; i++) push_exp(4, 4, 0, 0, 4, 4, 4, 4, 0);
    start();
    got = 0; prev = 0;
    for (int i = 0; i < 200 && got < 5; i++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        if (got == 0) check("b2b first latency", cyc - c0, 17);
        else          check("b2b interval", cyc - prev, 16);
        prev = cyc;
        got++;
      end
    end
    check("b2b snapshot count", got, 5);
    check("b2b overrun", bus.o_overrun, 0);
    tick();
    en = 1'b0;
    repeat (20) tick();

    // Overrun: k=1, period 0, continuous, consumer stalled
    kexp = 5'd1; period = 15'd0; ready = 1'b0;
    start();
    wait_valid("ovr first", 1'b0, 20, lat);
    check("ovr clear after first end", bus.o_overrun, 0);
    nv = 0;
    while (!bus.o_overrun && nv < 20) begin
      @(negedge clk);
      nv++;
    end
    check("ovr set on second end", bus.o_overrun, 1);
    check("ovr valid held", bus.o_valid, 1);
    tick();
    en = 1'b0;
    repeat (3) tick();
    push_exp(2, 2, 0, 0, 2, 2, 2, 2, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    @(negedge clk);
    check("ovr valid after accept", bus.o_valid, 0);
    check("ovr sticky", bus.o_overrun, 1);
    check("ovr busy", busy, 0);
    ready = 1'b1;
    repeat (3) tick();

    // One-shot with a mid-window k change; the restart clears overrun
    one_shot = 1'b1; kexp = 5'd3; period = 15'd0;
    push_exp(8, 8, 0, 0, 8, 8, 8, 8, 0);
    start();
    @(negedge clk);
    check("overrun held until start", bus.o_overrun, 1);
    @(negedge clk);
    check("overrun cleared by start", bus.o_overrun, 0);
    tick();
    kexp = 5'd5;
    wait_valid("oneshot", 1'b0, 40, lat);
    check("oneshot latency", lat, 9);
    tick();
    en = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("oneshot busy after accept", busy, 0);
    check("oneshot valid after accept", bus.o_valid, 0);

    // Abort at sample 5 of 16
    one_shot = 1'b0; kexp = 5'd4; period = 15'd0;
    start();
    repeat (5) tick();
    en = 1'b0;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) nv++;
    end
    check("abort valid cycles", nv, 0);
    check("abort busy", busy, 0);

    // Clock gate low for 10 cycles mid-window
    one_shot = 1'b1; kexp = 5'd4; period = 15'd0;
    push_exp(16, 16, 0, 0, 16, 16, 16, 16, 0);
    start();
    repeat (5) tick();
    cg = 1'b0;
    repeat (10) tick();
    cg = 1'b1;
    wait_valid("gated", 1'b0, 60, lat);
    check("gated latency", lat, 27);
    tick();
    en = 1'b0;
    repeat (4) tick();

    // Reset mid-window emits no snapshot
    one_shot = 1'b0;
    start();
    repeat (5) tick();
    rst_n = 1'b0; en = 1'b0;
    tick();
    rst_n = 1'b1;
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.o_valid || busy) nv++;
    end
    check("reset mid-window activity", nv, 0);

    // Out-of-range X select reads as zero
    one_shot = 1'b1; kexp = 5'd2; period = 15'd0;
    begin
      exp_t e;
      e.n = 4; e.x0 = 0; e.y0 = 4; e.i0 = 0; e.s0 = 4;
      e.x1 = 0; e.y1 = 0; e.i1 = 0; e.s1 = 0;
      exp2_q.push_back(e);
    end
    tick();
    en2 = 1'b1;
    c0 = cyc;
    wait_valid("oor", 1'b1, 30, lat);
    check("oor latency", lat, 5);
    tick();
    en2 = 1'b0;
    repeat (4) tick();

    check("pending expectations", exp_q.size(), 0);
    check("pending oor expectations", exp2_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
